// File: rtl/filter_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : filter_stream_gen
// Brief    : Generates read-address streams over a sequence of filters with
//            backpressure, hold/repeat control and abort.
// Revision : 1.0 - initial release
// ============================================================================
module filter_stream_gen #(
    parameter int ADDR_WIDTH = 8,
    parameter int SIZE_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [SIZE_WIDTH-1:0] filter_size,
    input  logic [CNT_WIDTH-1:0]  num_filters,
    input  logic                  auto_next,
    input  logic                  next_filter,
    input  logic                  repeat_filter,
    input  logic                  addr_ready,
    output logic                  addr_valid,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  filter_last,
    output logic [CNT_WIDTH-1:0]  filter_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    localparam logic [SIZE_WIDTH-1:0] c_size_one = SIZE_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  c_cnt_one  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_head;
    logic [SIZE_WIDTH-1:0] r_index;
    logic [SIZE_WIDTH-1:0] r_size;
    logic [CNT_WIDTH-1:0]  r_filter_idx;
    logic [CNT_WIDTH-1:0]  r_num;
    logic                  r_done;
    logic                  r_cfg_err;

    logic                  w_last_elem;
    logic                  w_last_filter;
    logic                  w_xfer;
    logic [ADDR_WIDTH-1:0] w_next_head;

    assign w_last_elem   = (r_index == (r_size - c_size_one));
    assign w_last_filter = (r_filter_idx == (r_num - c_cnt_one));
    assign w_xfer        = addr_valid && addr_ready;
    assign w_next_head   = r_head + ADDR_WIDTH'(r_size);

    assign addr_valid  = (r_state == ST_RUN);
    assign raddr       = r_head + ADDR_WIDTH'(r_index);
    assign filter_last = addr_valid && w_last_elem;
    assign filter_idx  = r_filter_idx;
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign cfg_err     = r_cfg_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_head       <= '0;
            r_index      <= '0;
            r_size       <= '0;
            r_filter_idx <= '0;
            r_num        <= '0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            if (abort) begin
                // Cancel beats everything, including a same-cycle final transfer.
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            if ((filter_size != '0) && (num_filters != '0)) begin
                                r_size       <= filter_size;
                                r_num        <= num_filters;
                                r_head       <= base_addr;
                                r_index      <= '0;
                                r_filter_idx <= '0;
                                r_state      <= ST_RUN;
                            end else begin
                                r_cfg_err <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (w_xfer) begin
                            if (!w_last_elem) begin
                                r_index <= r_index + c_size_one;
                            end else if (w_last_filter) begin
                                r_state <= ST_IDLE;
                                r_done  <= 1'b1;
                            end else if (auto_next) begin
                                r_head       <= w_next_head;
                                r_index      <= '0;
                                r_filter_idx <= r_filter_idx + c_cnt_one;
                            end else begin
                                r_state <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (next_filter) begin
                            r_head       <= w_next_head;
                            r_index      <= '0;
                            r_filter_idx <= r_filter_idx + c_cnt_one;
                            r_state      <= ST_RUN;
                        end else if (repeat_filter) begin
                            r_index <= '0;
                            r_state <= ST_RUN;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_filter_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_stream_gen
// Brief    : Scoreboard bench for filter_stream_gen with a list-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filter_stream_gen;

    localparam int AW = 8;
    localparam int SW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [SW-1:0] filter_size = '0;
    logic [CW-1:0] num_filters = '0;
    logic          auto_next = 1'b0;
    logic          next_filter = 1'b0;
    logic          repeat_filter = 1'b0;
    logic          addr_ready = 1'b0;
    logic          addr_valid;
    logic [AW-1:0] raddr;
    logic          filter_last;
    logic [CW-1:0] filter_idx;
    logic          busy;
    logic          done;
    logic          cfg_err;

    filter_stream_gen #(.ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_addr(base_addr), .filter_size(filter_size), .num_filters(num_filters),
        .auto_next(auto_next), .next_filter(next_filter), .repeat_filter(repeat_filter),
        .addr_ready(addr_ready), .addr_valid(addr_valid), .raddr(raddr),
        .filter_last(filter_last), .filter_idx(filter_idx), .busy(busy),
        .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        bit last;
        int idx;
        bit fin;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    bit   exp_done = 0;
    int   ready_mode = 0;   // 0 always ready, 1 random, 2 stalled
    int   plan_reps[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: the full address list of a sequence, expanded from the plan.
    task automatic start_seq(input int b, input int s, input int n, input bit an);
        for (int f = 0; f < n; f++) begin
            int reps;
            reps = an ? 0 : plan_reps[f];
            for (int r = 0; r <= reps; r++) begin
                for (int e = 0; e < s; e++) begin
                    exp_t x;
                    x.addr = (b + f * s + e) % 256;
                    x.last = (e == s - 1);
                    x.idx  = f;
                    x.fin  = (f == n - 1) && (e == s - 1) && (r == reps);
                    q.push_back(x);
                end
            end
        end
        base_addr   = AW'(b);
        filter_size = SW'(s);
        num_filters = CW'(n);
        auto_next   = an;
        start       = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(input bit scramble, output int cycles);
        int f;
        int rep;
        bit seen;
        f = 0; rep = 0; seen = 0; cycles = 0;
        for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
            next_filter   = 1'b0;
            repeat_filter = 1'b0;
            if (done) begin
                seen   = 1;
                cycles = cyc;
            end else begin
                if (busy && !addr_valid) begin
                    if (rep < plan_reps[f]) begin
                        repeat_filter = 1'b1;
                        rep++;
                    end else begin
                        next_filter   = 1'b1;
                        repeat_filter = 1'b1;
                        f++;
                        rep = 0;
                    end
                end
                if (scramble) begin
                    base_addr   = AW'($urandom);
                    filter_size = SW'($urandom);
                    num_filters = CW'($urandom);
                    start       = 1'($urandom_range(0, 1));
                end
                tick();
            end
        end
        start = 1'b0;
        check("done_seen", seen, 1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       addr_ready = 1'b1;
                1:       addr_ready = 1'($urandom_range(0, 1));
                default: addr_ready = 1'b0;
            endcase
        end
    end

    // Monitor: peek the head entry on every valid cycle, pop on transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (exp_done) begin
                    check("done_pulse", done, 1);
                    exp_done = 0;
                end else if (done) begin
                    check("done_unexpected", done, 0);
                end
                if (addr_valid) begin
                    if (q.size() == 0) begin
                        check("valid_unexpected", addr_valid, 0);
                    end else begin
                        check("raddr", raddr, q[0].addr);
                        check("filter_last", filter_last, q[0].last);
                        check("filter_idx", filter_idx, q[0].idx);
                        if (addr_ready) begin
                            if (q[0].fin) exp_done = 1;
                            void'(q.pop_front());
                        end
                    end
                end else if (filter_last) begin
                    check("last_without_valid", filter_last, 0);
                end
            end
        end
    end

    initial begin
        int cyc;
        int wait_cnt;
        for (int i = 0; i < 16; i++) plan_reps[i] = 0;

        repeat (2) @(negedge clk);
        check("rst_valid", addr_valid, 0);
        check("rst_last", filter_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_raddr", raddr, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Continuous stream with no bubbles
        start_seq(8'h10, 3, 2, 1);
        run_to_done(0, cyc);
        check("stream_cycles", cyc, 6);

        // Back-to-back start in the done cycle, then backpressure at 0x11
        start_seq(8'h10, 3, 2, 1);
        wait_cnt = 0;
        while (!(addr_valid && raddr == 8'h11) && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        check("reach_0x11", (wait_cnt < 20), 1);
        ready_mode = 2;
        repeat (3) tick();
        ready_mode = 0;
        run_to_done(0, cyc);

        // Hold, repeat, then next with repeat also asserted
        plan_reps[0] = 1;
        plan_reps[1] = 0;
        start_seq(8'h00, 2, 2, 0);
        run_to_done(0, cyc);
        plan_reps[0] = 0;

        // Address wrap
        start_seq(8'hFE, 4, 1, 1);
        run_to_done(0, cyc);
        tick();

        // Rejected configurations
        for (int k = 0; k < 2; k++) begin
            filter_size = (k == 0) ? 8'd0 : 8'd3;
            num_filters = (k == 0) ? 4'd2 : 4'd0;
            start = 1'b1;
            tick();
            start = 1'b0;
            check("cfg_err_pulse", cfg_err, 1);
            check("cfg_err_busy", busy, 0);
            tick();
            check("cfg_err_clear", cfg_err, 0);
            check("cfg_err_busy2", busy, 0);
        end

        // Abort beats a valid start in IDLE
        base_addr = 8'h33; filter_size = 8'd2; num_filters = 4'd1;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", busy, 0);
        check("abort_start_cfg_err", cfg_err, 0);

        // Abort during filter 1
        start_seq(8'h20, 4, 3, 1);
        wait_cnt = 0;
        while (!(addr_valid && filter_idx == 4'd1) && wait_cnt < 40) begin
            tick();
            wait_cnt++;
        end
        check("reach_filter1", (wait_cnt < 40), 1);
        abort = 1'b1;
        ready_mode = 2;
        tick();
        abort = 1'b0;
        q.delete();
        exp_done = 0;
        ready_mode = 0;
        check("abort_busy", busy, 0);
        check("abort_valid", addr_valid, 0);
        repeat (4) tick();
        check("abort_stays_idle", busy, 0);

        // Asynchronous reset mid-run
        start_seq(8'h40, 5, 2, 1);
        repeat (3) tick();
        #1 rst = 1'b1;
        #1;
        check("arst_valid", addr_valid, 0);
        check("arst_last", filter_last, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_raddr", raddr, 0);
        q.delete();
        exp_done = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) tick();
        check("post_rst_idle", busy, 0);
        start_seq(8'h80, 3, 2, 1);
        run_to_done(0, cyc);

        // Randomized sequences with random backpressure and input churn
        ready_mode = 1;
        for (int r = 0; r < 25; r++) begin
            int b, s, n;
            bit an;
            b  = $urandom_range(0, 255);
            s  = $urandom_range(1, 6);
            n  = $urandom_range(1, 4);
            an = 1'($urandom_range(0, 1));
            for (int f = 0; f < 16; f++) plan_reps[f] = (f < n - 1) ? $urandom_range(0, 2) : 0;
            start_seq(b, s, n, an);
            run_to_done(1, cyc);
            if ($urandom_range(0, 1) == 1) tick();
        end
        ready_mode = 0;
        repeat (3) tick();
        check("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
